// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: geometry of the 16x64 memory
// and the burst initiator state encoding.
package mem_pkg;

  localparam int MEM_WIDTH = 16;
  localparam int MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/mem_initiator.sv
// Burst initiator: turns one host command into len memory beats.
// Ports: cmd_* host command, valid_o/ready_i memory handshake,
// rd_* returned read beats, busy_o/done_o/err_o burst status.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_data_i,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  wr_q, wr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic                  err_q, err_d;
  logic                  valid_q, busy_q, done_q;
  logic                  cmd_ready_q;

  function automatic logic [ADDR_WIDTH-1:0] inc_addr(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a == LAST_A) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wr_d    = cmd_wr_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_data_i;
          rem_d   = cmd_len_i;
          tmo_d   = '0;
          state_d = (cmd_len_i == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        // A handshake on the last timeout cycle still counts.
        if (ready_i) begin
          rem_d   = rem_q - ONE;
          state_d = GAP;
          if (!wr_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rdata_i;
            rd_last_d  = (rem_q == ONE);
          end
        end else if (tmo_q == TMO_END) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        // ready_i is stale here and deliberately not looked at.
        if (rem_q != '0) begin
          state_d = REQ;
          addr_d  = inc_addr(addr_q);
          wdata_d = wdata_q + 1'b1;
          tmo_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      err_q       <= err_d;
      // Status flops track the next state so they line up with it.
      valid_q     <= (state_d == REQ);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign valid_o     = valid_q;
  assign wr_rd_en_o  = wr_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator against a 16x64 memory model.
// Expected beats come from address/data arithmetic on the command.
module tb_mem_initiator;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_i;
  logic [5:0]  cmd_addr_i;
  logic [6:0]  cmd_len_i;
  logic [15:0] cmd_data_i;
  logic        valid_o;
  logic        wr_rd_en_o;
  logic [5:0]  addr_o;
  logic [15:0] wdata_o;
  logic        ready_i;
  logic [15:0] rdata_i;
  logic        rd_valid_o;
  logic [15:0] rd_data_o;
  logic        rd_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_wr_i   (cmd_wr_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_len_i  (cmd_len_i),
    .cmd_data_i (cmd_data_i),
    .valid_o    (valid_o),
    .wr_rd_en_o (wr_rd_en_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .ready_i    (ready_i),
    .rdata_i    (rdata_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_last_o  (rd_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  typedef struct {
    logic        wr;
    logic [5:0]  a;
    logic [15:0] d;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } rd_t;

  beat_t       exp_beat[$];
  rd_t         exp_rd[$];
  bit          exp_done[$];
  logic [15:0] ref_mem[64];
  logic [15:0] sim_mem[64];

  int n_cmp = 0;
  int n_bad = 0;
  int vcyc = 0;
  int done_cnt = 0;
  int nbeat = 0;
  int wait_left = 0;
  bit stall = 0;

  beat_t m_b;
  rd_t   m_r;
  bit    m_e;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory device: random latency, never acks while stalled.
  initial begin
    ready_i = 1'b0;
    rdata_i = '0;
    forever begin
      @(negedge clk);
      ready_i = 1'b0;
      rdata_i = 16'($urandom);
      if (valid_o && !rst_i && !stall) begin
        if (wait_left == 0) begin
          ready_i = 1'b1;
          if (wr_rd_en_o) sim_mem[addr_o] = wdata_o;
          else rdata_i = sim_mem[addr_o];
          wait_left = $urandom_range(0, 3);
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i) begin
        if (valid_o) vcyc++;
        if (valid_o && ready_i) begin
          nbeat++;
          if (exp_beat.size() == 0) begin
            check("unexpected_beat", 32'(exp_beat.size()), 1);
          end else begin
            m_b = exp_beat.pop_front();
            check("beat_wr", 32'(wr_rd_en_o), 32'(m_b.wr));
            check("beat_addr", 32'(addr_o), 32'(m_b.a));
            if (m_b.wr) check("beat_wdata", 32'(wdata_o), 32'(m_b.d));
          end
        end
        if (rd_valid_o) begin
          if (exp_rd.size() == 0) begin
            check("unexpected_rd", 32'(exp_rd.size()), 1);
          end else begin
            m_r = exp_rd.pop_front();
            check("rd_data", 32'(rd_data_o), 32'(m_r.d));
            check("rd_last", 32'(rd_last_o), 32'(m_r.last));
          end
        end
        if (done_o) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            check("unexpected_done", 32'(exp_done.size()), 1);
          end else begin
            m_e = exp_done.pop_front();
            check("done_err", 32'(err_o), 32'(m_e));
          end
        end else if (err_o) begin
          check("err_without_done", 32'(err_o), 0);
        end
      end
    end
  end

  task automatic push_exp(input bit wr, input int a, input int len,
                          input logic [15:0] d, input bit tmo);
    beat_t b;
    rd_t   r;
    if (tmo) begin
      exp_done.push_back(1'b1);
    end else begin
      for (int k = 0; k < len; k++) begin
        b.wr = wr;
        b.a  = 6'((a + k) % 64);
        b.d  = d + 16'(k);
        exp_beat.push_back(b);
        if (wr) begin
          ref_mem[b.a] = b.d;
        end else begin
          r.d    = ref_mem[b.a];
          r.last = (k == len - 1);
          exp_rd.push_back(r);
        end
      end
      exp_done.push_back(1'b0);
    end
  endtask

  task automatic drive(input bit wr, input int a, input int len,
                       input logic [15:0] d);
    cmd_wr_i    = wr;
    cmd_addr_i  = 6'(a);
    cmd_len_i   = 7'(len);
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
  endtask

  task automatic issue(input bit wr, input int a, input int len,
                       input logic [15:0] d, input bit tmo);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready_o && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", 32'(cmd_ready_o), 1);
    push_exp(wr, a, len, d, tmo);
    drive(wr, a, len, d);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int w = 0;
    while (done_cnt < target && w < 3000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int d0;
    int v0;
    int b0;
    int w;
    int len;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_wr_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    cmd_data_i  = '0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      sim_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 1);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_rd_valid", 32'(rd_valid_o), 0);
    check("rst_addr", 32'(addr_o), 0);
    check("rst_wdata", 32'(wdata_o), 0);
    rst_i = 1'b0;

    // Write then read back addr 5..7.
    d0 = done_cnt;
    issue(1'b1, 5, 3, 16'h1000, 1'b0);
    wait_done(d0 + 1);
    check("mem5", 32'(sim_mem[5]), 32'h1000);
    check("mem6", 32'(sim_mem[6]), 32'h1001);
    check("mem7", 32'(sim_mem[7]), 32'h1002);
    d0 = done_cnt;
    issue(1'b0, 5, 3, 16'h0, 1'b0);
    wait_done(d0 + 1);

    // Wrap-around address and data.
    d0 = done_cnt;
    issue(1'b1, 62, 4, 16'hFFFE, 1'b0);
    wait_done(d0 + 1);
    check("mem0_wrap", 32'(sim_mem[0]), 32'h0000);
    check("mem1_wrap", 32'(sim_mem[1]), 32'h0001);
    d0 = done_cnt;
    issue(1'b0, 62, 4, 16'h0, 1'b0);
    wait_done(d0 + 1);

    // Timeout with memory never answering.
    stall = 1'b1;
    v0 = vcyc;
    d0 = done_cnt;
    issue(1'b0, 9, 2, 16'h0, 1'b1);
    wait_done(d0 + 1);
    check("tmo_valid_cycles", 32'(vcyc - v0), 15);
    stall = 1'b0;

    // Zero length: done one cycle after the accepting edge.
    v0 = vcyc;
    d0 = done_cnt;
    issue(1'b0, 3, 0, 16'h0, 1'b0);
    #2;
    check("zero_len_done", 32'(done_cnt), 32'(d0 + 1));
    check("zero_len_valid", 32'(vcyc - v0), 0);

    // Second command held during a burst waits for IDLE.
    d0 = done_cnt;
    issue(1'b1, 20, 3, 16'h2222, 1'b0);
    drive(1'b1, 40, 2, 16'h3333);
    w = 0;
    while (!cmd_ready_o && w < 3000) begin
      check("busy_while_held", 32'(busy_o), 1);
      @(negedge clk);
      w++;
    end
    check("first_done_before_accept", 32'(done_cnt), 32'(d0 + 1));
    push_exp(1'b1, 40, 2, 16'h3333, 1'b0);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wait_done(d0 + 2);

    // Reset during beat 2 of an 8-beat read.
    b0 = nbeat;
    issue(1'b0, 10, 8, 16'h0, 1'b0);
    w = 0;
    while (!(nbeat == b0 + 1 && valid_o) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("reached_beat2", 32'(nbeat), 32'(b0 + 1));
    rst_i = 1'b1;
    exp_beat.delete();
    exp_rd.delete();
    exp_done.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_ready", 32'(cmd_ready_o), 1);
    check("mid_rst_done", 32'(done_o), 0);
    rst_i = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt), 32'(d0));

    // Full-memory burst ending at start-1.
    d0 = done_cnt;
    issue(1'b1, 17, 64, 16'h4000, 1'b0);
    wait_done(d0 + 1);
    check("full_last_word", 32'(sim_mem[16]), 32'h403F);
    d0 = done_cnt;
    issue(1'b0, 17, 64, 16'h0, 1'b0);
    wait_done(d0 + 1);

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      len = ($urandom_range(0, 9) == 0) ? 64 : $urandom_range(0, 9);
      d0 = done_cnt;
      issue(1'($urandom), $urandom_range(0, 63), len,
            16'($urandom), 1'b0);
      wait_done(d0 + 1);
    end

    repeat (5) @(negedge clk);
    check("left_beats", 32'(exp_beat.size()), 0);
    check("left_rd", 32'(exp_rd.size()), 0);
    check("left_done", 32'(exp_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
